regfile_wb_arbiter: RTL and testbench

Write-port arbiter and register scoreboard for the MIPS pipeline register file. Two writeback sources share the file's single write port: the in-order pipeline WB stage (A) and a multicycle unit (B), e.g. mult/div or a slow load path. A has default priority; a starvation counter guarantees B forward progress. A 32-bit busy scoreboard tracks registers with outstanding B results, so decode can stall on RAW/WAW hazards.

---
 rtl/regfile_wb_arbiter.sv | 122 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Single-write-port arbiter for the register file: pipeline WB (A) has priority,
// multicycle unit (B) is forced through after STARVE_MAX blocked cycles.
module regfile_wb_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        a_valid,
    input  logic [4:0]  a_reg,
    input  logic [31:0] a_data,
    output logic        a_ready,

    input  logic        b_valid,
    input  logic [4:0]  b_reg,
    input  logic [31:0] b_data,
    output logic        b_ready,

    input  logic        b_issue,
    input  logic [4:0]  b_issue_reg,

    input  logic [4:0]  q_rs,
    input  logic [4:0]  q_rt,
    input  logic [4:0]  q_rd,
    output logic        rs_busy,
    output logic        rt_busy,
    output logic        rd_busy,

    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,

    output logic        sb_err
);

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    logic [7:0]  starve_cnt_reg;
    logic [7:0]  starve_cnt_next;
    logic [31:0] busy_reg;
    logic [31:0] busy_next;
    logic        sb_err_reg;
    logic        sb_err_next;

    logic        force_b;
    logic        grant_a;
    logic        grant_b;

    assign force_b = (starve_cnt_reg == STARVE_LIM);

    // Ready signals depend only on the other requester's valid, never on own valid.
    always_comb begin
        a_ready = !reset && !(b_valid && force_b);
        b_ready = !reset && (!a_valid || force_b);
        grant_b = b_valid && b_ready;
        grant_a = a_valid && a_ready && !grant_b;
    end

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'd0;
        if (grant_b) begin
            rf_we    = (b_reg != 5'd0);
            rf_waddr = b_reg;
            rf_wdata = b_data;
        end else if (grant_a) begin
            rf_we    = (a_reg != 5'd0);
            rf_waddr = a_reg;
            rf_wdata = a_data;
        end
    end

    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (grant_b || !b_valid) begin
            starve_cnt_next = 8'd0;
        end else if (a_valid && !force_b) begin
            starve_cnt_next = starve_cnt_reg + 8'd1;
        end
    end

    // Register 0 is hardwired idle; for the rest a same-edge issue beats the completion.
    assign busy_next[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < 32; gi = gi + 1) begin : g_busy
            logic set_bit;
            logic clr_bit;
            assign set_bit       = b_issue && (b_issue_reg == 5'(gi));
            assign clr_bit       = grant_b && (b_reg == 5'(gi));
            assign busy_next[gi] = set_bit || (busy_reg[gi] && !clr_bit);
        end
    endgenerate

    always_comb begin
        sb_err_next = sb_err_reg;
        if (b_issue && (b_issue_reg != 5'd0) && busy_reg[b_issue_reg]
                && !(grant_b && (b_reg == b_issue_reg))) begin
            sb_err_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_reg <= 8'd0;
            busy_reg       <= 32'd0;
            sb_err_reg     <= 1'b0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
            busy_reg       <= busy_next;
            sb_err_reg     <= sb_err_next;
        end
    end

    assign rs_busy = busy_reg[q_rs];
    assign rt_busy = busy_reg[q_rt];
    assign rd_busy = busy_reg[q_rd];
    assign sb_err  = sb_err_reg;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, A path, starvation, scoreboard, reset flush.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_valid, b_valid, b_issue;
    logic [4:0]  a_reg, b_reg, b_issue_reg, q_rs, q_rt, q_rd;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready, rs_busy, rt_busy, rd_busy, rf_we, sb_err;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
        .b_issue(b_issue), .b_issue_reg(b_issue_reg),
        .q_rs(q_rs), .q_rt(q_rt), .q_rd(q_rd),
        .rs_busy(rs_busy), .rt_busy(rt_busy), .rd_busy(rd_busy),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .sb_err(sb_err)
    );

    // Advance one clock, then settle 1 time unit past the edge before driving or sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_valid = 0; a_reg = 0; a_data = 0;
        b_valid = 0; b_reg = 0; b_data = 0;
        b_issue = 0; b_issue_reg = 0;
    endtask

    task automatic test_reset();
        reset = 1; a_valid = 1; a_reg = 3; a_data = 32'h11; b_valid = 1; b_reg = 4; b_data = 32'h22;
        #1;
        total_cnt++;
        if ({a_ready, b_ready, rf_we} !== 3'b000) $display("FAIL reset_ready_we got=%b want=000", {a_ready, b_ready, rf_we});
        else pass_cnt++;
        step();
        step();
        reset = 0;
        idle_inputs();
        #1;
        for (int r = 0; r < 32; r++) begin
            q_rs = 5'(r);
            #1;
            total_cnt++;
            if (rs_busy !== 1'b0) $display("FAIL reset_rs_busy reg=%0d got=%b want=0", r, rs_busy);
            else pass_cnt++;
        end
        total_cnt++;
        if (sb_err !== 1'b0) $display("FAIL reset_sb_err got=%b want=0", sb_err);
        else pass_cnt++;
        $display("txn reset: ready/we low in reset, busy clear after");
    endtask

    task automatic test_a_only();
        a_valid = 1; a_reg = 5; a_data = 32'hDEADBEEF;
        #1;
        total_cnt++;
        if ({a_ready, rf_we, rf_waddr, rf_wdata} !== {1'b1, 1'b1, 5'd5, 32'hDEADBEEF})
            $display("FAIL a_write got ready=%b we=%b addr=%0d data=%h want 1 1 5 deadbeef", a_ready, rf_we, rf_waddr, rf_wdata);
        else pass_cnt++;
        $display("txn A write reg5 data=%h", rf_wdata);
        step();
        a_reg = 0; a_data = 32'h12345678;
        #1;
        total_cnt++;
        if ({a_ready, rf_we} !== 2'b10) $display("FAIL a_reg0 got ready=%b we=%b want ready=1 we=0", a_ready, rf_we);
        else pass_cnt++;
        $display("txn A write reg0 (suppressed)");
        step();
        idle_inputs();
        #1;
        total_cnt++;
        if ({rf_we, rf_waddr, rf_wdata} !== 38'd0) $display("FAIL no_grant got we=%b addr=%0d data=%h want 0 0 0", rf_we, rf_waddr, rf_wdata);
        else pass_cnt++;
    endtask

    task automatic test_starvation();
        a_valid = 1; a_reg = 1; a_data = 32'hA0A0A0A0;
        b_valid = 1; b_reg = 9; b_data = 32'hB9B9B9B9;
        for (int c = 0; c < 4; c++) begin
            #1;
            total_cnt++;
            if ({b_ready, a_ready, rf_waddr} !== {1'b0, 1'b1, 5'd1})
                $display("FAIL starve_block cyc=%0d got b_ready=%b a_ready=%b addr=%0d want 0 1 1", c, b_ready, a_ready, rf_waddr);
            else pass_cnt++;
            step();
        end
        #1;
        total_cnt++;
        if ({b_ready, a_ready, rf_we, rf_waddr, rf_wdata} !== {1'b1, 1'b0, 1'b1, 5'd9, 32'hB9B9B9B9})
            $display("FAIL starve_force got b_ready=%b a_ready=%b we=%b addr=%0d data=%h want 1 0 1 9 b9b9b9b9", b_ready, a_ready, rf_we, rf_waddr, rf_wdata);
        else pass_cnt++;
        $display("txn B forced through reg9 after 4 blocked cycles");
        step();
        // A new B request must again wait the full four cycles, proving the counter restarted at 0.
        b_reg = 10; b_data = 32'hB10B10B1;
        for (int c = 5; c < 9; c++) begin
            #1;
            total_cnt++;
            if ({a_ready, b_ready} !== 2'b10) $display("FAIL starve_restart cyc=%0d got a_ready=%b b_ready=%b want 1 0", c, a_ready, b_ready);
            else pass_cnt++;
            step();
        end
        #1;
        total_cnt++;
        if ({b_ready, a_ready, rf_waddr} !== {1'b1, 1'b0, 5'd10})
            $display("FAIL starve_second got b_ready=%b a_ready=%b addr=%0d want 1 0 10", b_ready, a_ready, rf_waddr);
        else pass_cnt++;
        $display("txn B forced through reg10 after counter restart");
        step();
        idle_inputs();
    endtask

    task automatic test_scoreboard();
        q_rs = 12; q_rt = 12; q_rd = 13;
        b_issue = 1; b_issue_reg = 12;
        #1;
        total_cnt++;
        if (rs_busy !== 1'b0) $display("FAIL sb_issue_same_cycle got=%b want=0", rs_busy);
        else pass_cnt++;
        step();
        b_issue = 0;
        for (int c = 1; c < 6; c++) begin
            #1;
            total_cnt++;
            if ({rs_busy, rt_busy, rd_busy} !== 3'b110) $display("FAIL sb_busy cyc=%0d got=%b want=110", c, {rs_busy, rt_busy, rd_busy});
            else pass_cnt++;
            step();
        end
        b_valid = 1; b_reg = 12; b_data = 32'hC0DE0012;
        #1;
        total_cnt++;
        if ({b_ready, rf_we, rs_busy} !== 3'b111) $display("FAIL sb_complete got b_ready=%b we=%b rs_busy=%b want 111", b_ready, rf_we, rs_busy);
        else pass_cnt++;
        $display("txn B complete reg12");
        step();
        b_valid = 0;
        #1;
        total_cnt++;
        if (rs_busy !== 1'b0) $display("FAIL sb_clear got=%b want=0", rs_busy);
        else pass_cnt++;
        // Issues to register 0 are ignored and never flag an error.
        b_issue = 1; b_issue_reg = 0;
        step();
        step();
        b_issue = 0; q_rs = 0;
        #1;
        total_cnt++;
        if ({rs_busy, sb_err} !== 2'b00) $display("FAIL sb_reg0 got busy=%b err=%b want 00", rs_busy, sb_err);
        else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        q_rs = 12;
        b_issue = 1; b_issue_reg = 12;
        step();
        b_valid = 1; b_reg = 12; b_data = 32'h0000AAAA;
        #1;
        total_cnt++;
        if (b_ready !== 1'b1) $display("FAIL simul_b_ready got=%b want=1", b_ready);
        else pass_cnt++;
        $display("txn B complete reg12 with same-edge reissue");
        step();
        b_valid = 0; b_issue = 0;
        #1;
        total_cnt++;
        if ({rs_busy, sb_err} !== 2'b10) $display("FAIL simul_set_wins got busy=%b err=%b want 10", rs_busy, sb_err);
        else pass_cnt++;
        b_issue = 1; b_issue_reg = 12;
        step();
        b_issue = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            total_cnt++;
            if (sb_err !== 1'b1) $display("FAIL sb_err_sticky cyc=%0d got=%b want=1", c, sb_err);
            else pass_cnt++;
            step();
        end
    endtask

    task automatic test_mid_reset();
        b_issue = 1; b_issue_reg = 3;  step();
        b_issue_reg = 7;  step();
        b_issue_reg = 31; step();
        b_issue = 0;
        q_rs = 3; q_rt = 7; q_rd = 31;
        #1;
        total_cnt++;
        if ({rs_busy, rt_busy, rd_busy} !== 3'b111) $display("FAIL mid_busy_set got=%b want=111", {rs_busy, rt_busy, rd_busy});
        else pass_cnt++;
        a_valid = 1; a_reg = 2; a_data = 32'h2; b_valid = 1; b_reg = 4; b_data = 32'h4;
        step();
        step();
        reset = 1;
        step();
        reset = 0;
        #1;
        total_cnt++;
        if ({rs_busy, rt_busy, rd_busy, sb_err} !== 4'b0000) $display("FAIL mid_reset_clear got=%b want=0000", {rs_busy, rt_busy, rd_busy, sb_err});
        else pass_cnt++;
        for (int c = 0; c < 4; c++) begin
            #1;
            total_cnt++;
            if ({a_ready, b_ready, rf_waddr} !== {1'b1, 1'b0, 5'd2})
                $display("FAIL mid_post_a cyc=%0d got a_ready=%b b_ready=%b addr=%0d want 1 0 2", c, a_ready, b_ready, rf_waddr);
            else pass_cnt++;
            step();
        end
        #1;
        total_cnt++;
        if ({b_ready, a_ready} !== 2'b10) $display("FAIL mid_post_force got b_ready=%b a_ready=%b want 1 0", b_ready, a_ready);
        else pass_cnt++;
        $display("txn post-reset conflict: A first, B forced after 4 cycles");
        step();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 1; q_rs = 0; q_rt = 0; q_rd = 0;
        #1;
        test_reset();
        test_a_only();
        test_starvation();
        test_scoreboard();
        test_simultaneous();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
